// File: rtl/gem_ext_fifo_tx_buf.sv
// AXI4-Stream to GEM external-FIFO Tx bridge with a tagged frame buffer (store-and-forward or cut-through).
// Define GEM_TX_STATS_EN to add the frame/underflow/error-status counters.
module gem_ext_fifo_tx_buf #(
  parameter int DEPTH     = 2048,
  parameter int STORE_FWD = 1,
  parameter int FCNT_W    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  gem_data,
  output logic        gem_data_valid,
  output logic        gem_data_ready,
  input  logic        gem_data_rd_request,
  output logic        gem_sop,
  output logic        gem_eop,
  output logic        gem_err,
  output logic        gem_underflow,
  output logic        gem_flushed,
  output logic        gem_control,
  input  logic        gem_dma_tx_end_tog,
  output logic        gem_dma_tx_status_tog,
  input  logic [3:0]  gem_status,
  output logic [3:0]  tx_status_q
`ifdef GEM_TX_STATS_EN
  ,
  output logic [31:0] tx_frames_o,
  output logic [15:0] tx_underflows_o,
  output logic [15:0] tx_err_frames_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   PTR_ONE  = 1;
  localparam logic [FCNT_W-1:0] FCNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_FLUSH
  } state_t;

  // Entry layout: {tuser, tlast, tdata[7:0]}
  logic [9:0]        r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [FCNT_W-1:0] r_frame_cnt;
  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_sop;
  logic       r_eop;
  logic       r_err;
  logic       r_underflow;
  logic       r_flushed;
  logic       r_end_tog_q;
  logic       r_edge_d;
  logic       r_status_tog;
  logic [3:0] r_tx_status;

  logic       w_empty;
  logic       w_full;
  logic       w_fcnt_sat;
  logic       w_wr_en;
  logic       w_offer;
  logic       w_pop;
  logic       w_present;
  logic       w_sop;
  logic       w_underflow;
  logic       w_flush_done;
  logic       w_ready;
  logic       w_fcnt_inc;
  logic       w_fcnt_dec;
  logic       w_st_edge;
  logic [9:0] w_head;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_fcnt_sat = &r_frame_cnt;
  assign w_wr_en    = s_axis_tvalid && s_axis_tready;
  assign w_head     = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_fcnt_inc = w_wr_en && s_axis_tlast;
  assign w_fcnt_dec = w_pop && w_head[8];
  assign w_st_edge  = (gem_dma_tx_end_tog != r_end_tog_q);

  // A full buffer holding no complete frame can never drain in store-and-forward,
  // so it falls back to cut-through for that frame.
  assign w_offer = (STORE_FWD != 0) ? ((r_frame_cnt != '0) || w_full) : !w_empty;

  assign s_axis_tready         = !w_full && !w_fcnt_sat;
  assign gem_data_ready        = w_ready;
  assign gem_data              = r_data;
  assign gem_data_valid        = r_valid;
  assign gem_sop               = r_sop;
  assign gem_eop               = r_eop;
  assign gem_err               = r_err;
  assign gem_underflow         = r_underflow;
  assign gem_flushed           = r_flushed;
  assign gem_control           = 1'b0;
  assign gem_dma_tx_status_tog = r_status_tog;
  assign tx_status_q           = r_tx_status;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_fcnt_inc, w_fcnt_dec})
        2'b10:   r_frame_cnt <= r_frame_cnt + FCNT_ONE;
        2'b01:   r_frame_cnt <= r_frame_cnt - FCNT_ONE;
        default: r_frame_cnt <= r_frame_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_present    = 1'b0;
    w_sop        = 1'b0;
    w_underflow  = 1'b0;
    w_flush_done = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = w_offer;
        if (gem_data_rd_request && w_offer) begin
          w_pop     = 1'b1;
          w_present = 1'b1;
          w_sop     = 1'b1;
          if (!w_head[8]) begin
            w_state_nxt = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (gem_data_rd_request) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_present = 1'b1;
            if (w_head[8]) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_underflow = 1'b1;
            w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Discard the rest of the aborted frame regardless of MAC requests.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[8]) begin
            w_flush_done = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_err       <= 1'b0;
      r_underflow <= 1'b0;
      r_flushed   <= 1'b0;
    end else begin
      if (w_present) begin
        r_data <= w_head[7:0];
      end
      r_valid     <= w_present;
      r_sop       <= w_sop;
      r_eop       <= w_present && w_head[8];
      r_err       <= w_present && w_head[8] && w_head[9];
      r_underflow <= w_underflow;
      r_flushed   <= w_flush_done;
    end
  end

  // Every end_tog edge is captured at once and acknowledged one cycle later,
  // so back-to-back edges produce back-to-back acknowledge toggles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_end_tog_q  <= 1'b0;
      r_edge_d     <= 1'b0;
      r_status_tog <= 1'b0;
      r_tx_status  <= '0;
    end else begin
      r_end_tog_q <= gem_dma_tx_end_tog;
      r_edge_d    <= w_st_edge;
      if (w_st_edge) begin
        r_tx_status <= gem_status;
      end
      if (r_edge_d) begin
        r_status_tog <= !r_status_tog;
      end
    end
  end

`ifdef GEM_TX_STATS_EN
  logic [31:0] r_tx_frames;
  logic [15:0] r_tx_underflows;
  logic [15:0] r_tx_err_frames;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_frames     <= '0;
      r_tx_underflows <= '0;
      r_tx_err_frames <= '0;
    end else begin
      if (w_present && w_head[8]) begin
        r_tx_frames <= r_tx_frames + 32'd1;
      end
      if (w_underflow) begin
        r_tx_underflows <= r_tx_underflows + 16'd1;
      end
      if (w_st_edge && (gem_status != '0)) begin
        r_tx_err_frames <= r_tx_err_frames + 16'd1;
      end
    end
  end

  assign tx_frames_o     = r_tx_frames;
  assign tx_underflows_o = r_tx_underflows;
  assign tx_err_frames_o = r_tx_err_frames;
`endif

endmodule

// File: tb/tb_gem_ext_fifo_tx_buf.sv
// Scoreboard bench for gem_ext_fifo_tx_buf: three instances (store-and-forward, cut-through, DEPTH=16).
module tb_gem_ext_fifo_tx_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [7:0] tdata [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       tlast [3];
  logic       tuser [3];
  logic [7:0] gdata [3];
  logic       gvalid [3];
  logic       gready [3];
  logic       rdreq [3];
  logic       gsop [3];
  logic       geop [3];
  logic       gerr [3];
  logic       gund [3];
  logic       gflush [3];
  logic       gctl [3];
  logic       endtog [3];
  logic       sttog [3];
  logic [3:0] gstatus [3];
  logic [3:0] stq [3];
`ifdef GEM_TX_STATS_EN
  logic [31:0] txf [3];
  logic [15:0] txu [3];
  logic [15:0] txe [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SF = (g == 1) ? 0 : 1;
    localparam int DP = (g == 2) ? 16 : 2048;
    gem_ext_fifo_tx_buf #(.DEPTH(DP), .STORE_FWD(SF), .FCNT_W(8)) u_dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .s_axis_tdata         (tdata[g]),
      .s_axis_tvalid        (tvalid[g]),
      .s_axis_tready        (tready[g]),
      .s_axis_tlast         (tlast[g]),
      .s_axis_tuser         (tuser[g]),
      .gem_data             (gdata[g]),
      .gem_data_valid       (gvalid[g]),
      .gem_data_ready       (gready[g]),
      .gem_data_rd_request  (rdreq[g]),
      .gem_sop              (gsop[g]),
      .gem_eop              (geop[g]),
      .gem_err              (gerr[g]),
      .gem_underflow        (gund[g]),
      .gem_flushed          (gflush[g]),
      .gem_control          (gctl[g]),
      .gem_dma_tx_end_tog   (endtog[g]),
      .gem_dma_tx_status_tog(sttog[g]),
      .gem_status           (gstatus[g]),
      .tx_status_q          (stq[g])
`ifdef GEM_TX_STATS_EN
      ,
      .tx_frames_o          (txf[g]),
      .tx_underflows_o      (txu[g]),
      .tx_err_frames_o      (txe[g])
`endif
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q [$];
  int sel = 0;
  int und_cnt = 0;
  int flush_cnt = 0;
  int tog_cnt = 0;
  logic prev_tog = 1'b0;
  int early_ready = 0;
  logic sf_watch = 1'b0;
  int stall_beat = -1;
  int frames_exp [3] = '{0, 0, 0};
  int errstat_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Output monitor: pops one expected {sop,eop,err,data} per presented byte.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (gvalid[sel]) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(gvalid[sel]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", {21'b0, gsop[sel], geop[sel], gerr[sel], gdata[sel]}, {21'b0, e});
          end
        end
        if (gund[sel]) und_cnt++;
        if (gflush[sel]) flush_cnt++;
        if (sf_watch && gready[sel]) early_ready++;
        if (sttog[0] !== prev_tog) tog_cnt++;
        prev_tog = sttog[0];
      end
    end
  end

  task automatic push_beat(input int i, input int idx, input logic [7:0] d, input logic last,
                           input logic user, input logic track, input logic first);
    int n = 0;
    @(negedge clk);
    tdata[i]  = d;
    tvalid[i] = 1'b1;
    tlast[i]  = last;
    tuser[i]  = user;
    while (!tready[i] && n < 500) begin
      if (stall_beat < 0) stall_beat = idx;
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("tready_timeout", 32'(tready[i]), 32'd1);
    if (track) exp_q.push_back({first, last, last & user, d});
  endtask

  task automatic writer_idle(input int i);
    @(negedge clk);
    tvalid[i] = 1'b0;
    tlast[i]  = 1'b0;
    tuser[i]  = 1'b0;
  endtask

  // tuser is driven inverted on non-last beats: only the tlast beat may matter.
  task automatic send_frame(input int i, input int len, input logic [7:0] base, input logic user);
    for (int k = 0; k < len; k++) begin
      logic last;
      last = (k == len - 1);
      push_beat(i, k, base + 8'(k), last, last ? user : ~user, 1'b1, k == 0);
      if (last) sf_watch = 1'b0;
    end
    writer_idle(i);
    frames_exp[i]++;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_eop(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!geop[sel] && n < bound);
    if (!geop[sel]) chk("eop_timeout", 32'(geop[sel]), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] st_seq [3];
    st_seq = '{4'h0, 4'h4, 4'h8};
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tdata[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0; tuser[i] = 1'b0;
      rdreq[i] = 1'b0; endtog[i] = 1'b0; gstatus[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("rst_outs", 32'({gdata[i], gvalid[i], gready[i], gsop[i], geop[i], gerr[i],
                           gund[i], gflush[i], gctl[i], sttog[i], stq[i]}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tready", 32'(tready[i]), 32'd1);
      chk("post_rst_outs", 32'({gdata[i], gvalid[i], gready[i], gsop[i], geop[i], gerr[i],
                                gund[i], gflush[i], gctl[i], sttog[i], stq[i]}), 32'd0);
    end

    // Store-and-forward 64-byte frame, MAC pulling throughout.
    sel = 0; rdreq[0] = 1'b1; sf_watch = 1'b1; early_ready = 0;
    send_frame(0, 64, 8'h00, 1'b0);
    chk("sf_early_ready", 32'(early_ready), 32'd0);
    wait_drain(300);

    // Back-to-back 1-byte and 60-byte (tuser=1) frames.
    rdreq[0] = 1'b0;
    send_frame(0, 1, 8'hA0, 1'b0);
    send_frame(0, 60, 8'h40, 1'b1);
    chk("fcnt_two", 32'(g_dut[0].u_dut.r_frame_cnt), 32'd2);
    rdreq[0] = 1'b1;
    wait_eop(50);
    chk("fcnt_one", 32'(g_dut[0].u_dut.r_frame_cnt), 32'd1);
    wait_eop(200);
    chk("fcnt_zero", 32'(g_dut[0].u_dut.r_frame_cnt), 32'd0);
    wait_drain(100);

    // Status handshake, edges on consecutive cycles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      endtog[0] = ~endtog[0];
      gstatus[0] = st_seq[k];
      if (st_seq[k] != 4'h0) errstat_exp++;
    end
    @(negedge clk);
    gstatus[0] = 4'hF;
    repeat (5) @(negedge clk);
    chk("status_tog_count", 32'(tog_cnt), 32'd3);
    chk("tx_status_q", 32'(stq[0]), 32'h8);

    // DEPTH=16 store-and-forward, 20-byte frame: full fallback.
    sel = 2; rdreq[2] = 1'b1; stall_beat = -1;
    send_frame(2, 20, 8'h80, 1'b0);
    chk("full_stall_beat", 32'(stall_beat), 32'd16);
    wait_drain(200);

    // Cut-through underflow and flush.
    sel = 1; rdreq[1] = 1'b1; und_cnt = 0; flush_cnt = 0;
    for (int k = 0; k < 10; k++) push_beat(1, k, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1, k == 0);
    writer_idle(1);
    repeat (6) @(negedge clk);
    chk("underflow_pulse", 32'(und_cnt), 32'd1);
    chk("no_early_flush", 32'(flush_cnt), 32'd0);
    for (int k = 0; k < 6; k++) push_beat(1, k, 8'h20 + 8'(k), k == 5, 1'b0, 1'b0, 1'b0);
    writer_idle(1);
    repeat (10) @(negedge clk);
    chk("underflow_once", 32'(und_cnt), 32'd1);
    chk("flushed_once", 32'(flush_cnt), 32'd1);
    chk("ct_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef GEM_TX_STATS_EN
    chk("stat_frames0", txf[0], 32'(frames_exp[0]));
    chk("stat_frames1", txf[1], 32'd0);
    chk("stat_frames2", txf[2], 32'(frames_exp[2]));
    chk("stat_err0", 32'(txe[0]), 32'(errstat_exp));
    chk("stat_und1", 32'(txu[1]), 32'd1);
`endif

    // Reset with a partial frame buffered: ready must drop immediately.
    rdreq[1] = 1'b0;
    for (int k = 0; k < 3; k++) push_beat(1, k, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    writer_idle(1);
    chk("ct_ready_partial", 32'(gready[1]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_ready_drop", 32'(gready[1]), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(gready[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
